// File: rtl/decoder_host_driver.sv
// rtl/decoder_host_driver.sv - host-side framer/parser for the decoder byte-stream link
// Optional round-trip latency counter: DRIVER_LATENCY_COUNTER_EN.
module decoder_host_driver #(
    parameter int         GRID_WIDTH_X            = 4,
    parameter int         GRID_WIDTH_Z            = 1,
    parameter int         GRID_WIDTH_U            = 3,
    parameter int         TIMEOUT_CYCLES          = 65535,
    parameter logic [7:0] START_DECODING_MSG      = 8'hA5,
    parameter logic [7:0] MEASUREMENT_DATA_HEADER = 8'h5A,
    localparam int        MEAS_BYTES              = (GRID_WIDTH_X * GRID_WIDTH_Z + 7) / 8,
    localparam int        MEAS_W                  = 8 * MEAS_BYTES,
    localparam int        CORR_W                  = 2 * (GRID_WIDTH_X - 1) * GRID_WIDTH_Z + 1
                                                    + GRID_WIDTH_X * GRID_WIDTH_Z,
    localparam int        CORR_BYTES              = (CORR_W + 7) / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [MEAS_W-1:0] meas_data,
    input  logic              meas_valid,
    output logic              meas_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [CORR_W-1:0] corr_data,
    output logic              corr_valid,
    input  logic              corr_ready,
    output logic [7:0]        iteration_count,
    output logic [15:0]       cycle_count,
    output logic              stats_valid,
    output logic              busy,
    output logic              timeout_error
`ifdef DRIVER_LATENCY_COUNTER_EN
    ,
    output logic [31:0]       round_trip_cycles
`endif
);

    localparam int RW  = $clog2(GRID_WIDTH_U + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int MBW = (MEAS_BYTES > 1) ? $clog2(MEAS_BYTES) : 1;
    localparam int CBW = (CORR_BYTES > 1) ? $clog2(CORR_BYTES) : 1;
    localparam logic [RW-1:0]  U_L      = RW'(GRID_WIDTH_U);
    localparam logic [RW-1:0]  U_LAST   = RW'(GRID_WIDTH_U - 1);
    localparam logic [MBW-1:0] MB_LAST  = MBW'(MEAS_BYTES - 1);
    localparam logic [CBW-1:0] CB_LAST  = CBW'(CORR_BYTES - 1);
    localparam logic [TW-1:0]  TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {T_START, T_IDLE, T_HDR, T_LOAD, T_SEND, T_WAIT} tx_state_t;
    typedef enum logic [2:0] {R_ITER, R_CYC_HI, R_CYC_LO, R_CORR, R_OUT} rx_state_t;

    tx_state_t           tx_state, tx_state_n;
    rx_state_t           rx_state, rx_state_n;
    logic                tx_valid_n;
    logic [7:0]          tx_data_n;
    logic [MEAS_W-1:0]   meas_q, meas_q_n;
    logic [RW-1:0]       round_cnt, round_cnt_n;
    logic [MBW-1:0]      byte_cnt, byte_cnt_n;
    logic [CORR_BYTES*8-1:0] corr_sh;
    logic [CORR_BYTES*8+7:0] corr_cat;
    logic [CBW-1:0]      corr_idx;
    logic [RW-1:0]       rx_round;
    logic [TW-1:0]       wait_cnt;
    logic                rx_fire, frame_done, timeout_hit;

    // rx_ready is gated by reset so every output reads 0 while reset is held
    assign rx_ready    = reset && (rx_state != R_OUT);
    assign rx_fire     = rx_valid && rx_ready;
    assign corr_valid  = (rx_state == R_OUT);
    assign corr_data   = corr_sh[CORR_W-1:0];
    assign corr_cat    = {rx_data, corr_sh};
    assign frame_done  = corr_valid && corr_ready && (rx_round == U_LAST);
    assign timeout_hit = (tx_state == T_WAIT) && !rx_fire && !frame_done && (wait_cnt == TO_LAST);
    assign busy        = (tx_state == T_HDR) || (tx_state == T_LOAD) ||
                         (tx_state == T_SEND) || (tx_state == T_WAIT);

    generate
        if (CORR_BYTES * 8 > CORR_W) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^corr_sh[CORR_BYTES*8-1:CORR_W];
        end
    endgenerate

    always_comb begin
        tx_state_n  = tx_state;
        tx_valid_n  = tx_valid;
        tx_data_n   = tx_data;
        meas_q_n    = meas_q;
        round_cnt_n = round_cnt;
        byte_cnt_n  = byte_cnt;
        meas_ready  = 1'b0;
        // Each byte is loaded into the register first, then held until taken
        case (tx_state)
            T_START: begin
                if (!tx_valid) begin
                    tx_valid_n = 1'b1;
                    tx_data_n  = START_DECODING_MSG;
                end else if (tx_ready) begin
                    tx_valid_n = 1'b0;
                    tx_state_n = T_IDLE;
                end
            end
            T_IDLE: if (meas_valid) tx_state_n = T_HDR;
            T_HDR: begin
                if (!tx_valid) begin
                    tx_valid_n = 1'b1;
                    tx_data_n  = MEASUREMENT_DATA_HEADER;
                end else if (tx_ready) begin
                    tx_valid_n = 1'b0;
                    tx_state_n = T_LOAD;
                end
            end
            T_LOAD: begin
                meas_ready = 1'b1;
                if (meas_valid) begin
                    meas_q_n    = meas_data;
                    round_cnt_n = round_cnt + 1'b1;
                    byte_cnt_n  = '0;
                    tx_state_n  = T_SEND;
                end
            end
            T_SEND: begin
                if (!tx_valid) begin
                    tx_valid_n = 1'b1;
                    tx_data_n  = meas_q[7:0];
                    meas_q_n   = meas_q >> 8;
                end else if (tx_ready) begin
                    tx_valid_n = 1'b0;
                    if (byte_cnt == MB_LAST) begin
                        if (round_cnt < U_L) begin
                            tx_state_n = T_LOAD;
                        end else begin
                            tx_state_n  = T_WAIT;
                            round_cnt_n = '0;
                        end
                    end else begin
                        byte_cnt_n = byte_cnt + 1'b1;
                    end
                end
            end
            T_WAIT: if (frame_done || timeout_hit) tx_state_n = T_IDLE;
            default: tx_state_n = T_START;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state  <= T_START;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            meas_q    <= '0;
            round_cnt <= '0;
            byte_cnt  <= '0;
        end else begin
            tx_state  <= tx_state_n;
            tx_valid  <= tx_valid_n;
            tx_data   <= tx_data_n;
            meas_q    <= meas_q_n;
            round_cnt <= round_cnt_n;
            byte_cnt  <= byte_cnt_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        case (rx_state)
            R_ITER:   if (rx_fire) rx_state_n = R_CYC_HI;
            R_CYC_HI: if (rx_fire) rx_state_n = R_CYC_LO;
            R_CYC_LO: if (rx_fire) rx_state_n = R_CORR;
            R_CORR:   if (rx_fire && corr_idx == CB_LAST) rx_state_n = R_OUT;
            R_OUT:    if (corr_ready) rx_state_n = (rx_round == U_LAST) ? R_ITER : R_CORR;
            default:  rx_state_n = R_ITER;
        endcase
        if (timeout_hit) rx_state_n = R_ITER;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state        <= R_ITER;
            iteration_count <= '0;
            cycle_count     <= '0;
            stats_valid     <= 1'b0;
            corr_sh         <= '0;
            corr_idx        <= '0;
            rx_round        <= '0;
            wait_cnt        <= '0;
            timeout_error   <= 1'b0;
        end else begin
            rx_state    <= rx_state_n;
            stats_valid <= rx_fire && (rx_state == R_CYC_LO);
            if (rx_fire) begin
                case (rx_state)
                    R_ITER:   iteration_count    <= rx_data;
                    R_CYC_HI: cycle_count[15:8]  <= rx_data;
                    R_CYC_LO: cycle_count[7:0]   <= rx_data;
                    R_CORR: begin
                        corr_sh  <= corr_cat[CORR_BYTES*8+7:8];
                        corr_idx <= (corr_idx == CB_LAST) ? '0 : corr_idx + 1'b1;
                    end
                    default: ;
                endcase
            end
            if (corr_valid && corr_ready)
                rx_round <= (rx_round == U_LAST) ? '0 : rx_round + 1'b1;
            wait_cnt <= ((tx_state == T_WAIT) && !rx_fire) ? wait_cnt + 1'b1 : '0;
            if (timeout_hit) begin
                timeout_error <= 1'b1;
                rx_round      <= '0;
                corr_idx      <= '0;
                wait_cnt      <= '0;
            end
        end
    end

`ifdef DRIVER_LATENCY_COUNTER_EN
    logic [31:0] lat_cnt;
    logic        lat_run, hdr_fire, last_corr_byte;

    assign hdr_fire       = (tx_state == T_HDR) && tx_valid && tx_ready;
    assign last_corr_byte = rx_fire && (rx_state == R_CORR) && (corr_idx == CB_LAST) &&
                            (rx_round == U_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_cnt           <= '0;
            lat_run           <= 1'b0;
            round_trip_cycles <= '0;
        end else begin
            if (hdr_fire) begin
                lat_cnt <= '0;
                lat_run <= 1'b1;
            end else if (lat_run) begin
                if (lat_cnt != 32'hFFFF_FFFF) lat_cnt <= lat_cnt + 32'd1;
                if (last_corr_byte) lat_run <= 1'b0;
            end
            if (timeout_hit) begin
                round_trip_cycles <= 32'hFFFF_FFFF;
                lat_run           <= 1'b0;
            end else if (frame_done) begin
                round_trip_cycles <= lat_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_decoder_host_driver.sv
// tb/tb_decoder_host_driver.sv - directed self-checking bench for decoder_host_driver
module tb_decoder_host_driver;
    localparam logic [7:0] START = 8'hA5;
    localparam logic [7:0] HDR   = 8'h5A;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  meas_data;
    logic        meas_valid, meas_ready;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ready;
    logic [10:0] corr_data;
    logic        corr_valid, corr_ready;
    logic [7:0]  iteration_count;
    logic [15:0] cycle_count;
    logic        stats_valid, busy, timeout_error;
`ifdef DRIVER_LATENCY_COUNTER_EN
    logic [31:0] round_trip_cycles;
`endif

    decoder_host_driver #(
        .GRID_WIDTH_X(4), .GRID_WIDTH_Z(1), .GRID_WIDTH_U(3), .TIMEOUT_CYCLES(16),
        .START_DECODING_MSG(START), .MEASUREMENT_DATA_HEADER(HDR)
    ) dut (
        .clk(clk), .reset(reset),
        .meas_data(meas_data), .meas_valid(meas_valid), .meas_ready(meas_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .corr_data(corr_data), .corr_valid(corr_valid), .corr_ready(corr_ready),
        .iteration_count(iteration_count), .cycle_count(cycle_count),
        .stats_valid(stats_valid), .busy(busy), .timeout_error(timeout_error)
`ifdef DRIVER_LATENCY_COUNTER_EN
        , .round_trip_cycles(round_trip_cycles)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    int          meas_hs = 0, stats_pulses = 0, hold = 0;
    bit          tog_tx = 1'b0, stall_corr = 1'b0;
    logic [7:0]  exp_tx[$], tx_log[$];
    logic [10:0] exp_corr[$], corr_log[$];
    logic [23:0] exp_stats[$];
    logic [7:0]  resp [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=no-event required=event", name);
    endtask

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            tx_ready = tog_tx ? ~tx_ready : 1'b1;
        end
    end

    // Consumer that, when stalling, holds corr_ready low for 10 cycles of each word
    initial begin
        corr_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (!stall_corr) begin
                corr_ready = 1'b1;
                hold = 0;
            end else if (corr_valid) begin
                if (hold >= 10) corr_ready = 1'b1;
                else begin corr_ready = 1'b0; hold++; end
            end else begin
                corr_ready = 1'b0;
                hold = 0;
            end
        end
    end

    logic        prev_tx_stall = 1'b0, prev_corr_stall = 1'b0, prev_stats = 1'b0;
    logic [7:0]  prev_tx_data;
    logic [10:0] prev_corr_data;

    initial forever begin
        @(negedge clk);
        if (reset !== 1'b1) begin
            prev_tx_stall = 1'b0; prev_corr_stall = 1'b0; prev_stats = 1'b0;
        end else begin
            if (prev_tx_stall) begin
                chk("tx_hold_valid", tx_valid, 1);
                chk("tx_hold_data", tx_data, prev_tx_data);
            end
            if (prev_corr_stall) begin
                chk("corr_hold_valid", corr_valid, 1);
                chk("corr_hold_data", corr_data, prev_corr_data);
            end
            if (tx_valid && tx_ready) begin
                tx_log.push_back(tx_data);
                if (exp_tx.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_extra_byte actual=%h required=none", tx_data);
                end else chk("tx_byte", tx_data, exp_tx.pop_front());
            end
            if (corr_valid && corr_ready) begin
                corr_log.push_back(corr_data);
                if (exp_corr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL corr_extra_word actual=%h required=none", corr_data);
                end else chk("corr_word", corr_data, exp_corr.pop_front());
            end
            if (corr_valid) chk("rx_ready_low_in_out", rx_ready, 0);
            if (stats_valid) begin
                stats_pulses++;
                chk("stats_single_pulse", prev_stats, 0);
                if (exp_stats.size() == 0) miss("stats_expected");
                else chk("stats_values", {iteration_count, cycle_count}, exp_stats.pop_front());
            end
            if (meas_valid && meas_ready) meas_hs++;
            prev_tx_stall   = tx_valid && !tx_ready;
            prev_tx_data    = tx_data;
            prev_corr_stall = corr_valid && !corr_ready;
            prev_corr_data  = corr_data;
            prev_stats      = stats_valid;
        end
    end

    task automatic send_round(input logic [7:0] w);
        int n;
        meas_data  = w;
        meas_valid = 1'b1;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (meas_ready) break;
        end
        if (n == 200) miss("meas_accept");
        @(posedge clk); #1;
        meas_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        exp_tx.push_back(HDR);
        exp_tx.push_back(a);
        exp_tx.push_back(b);
        exp_tx.push_back(c);
        send_round(a);
        send_round(b);
        send_round(c);
    endtask

    // Returns just before the edge that takes the last queued tx byte
    task automatic wait_drain();
        int n;
        for (n = 0; n < 400; n++) begin
            @(negedge clk); #1;
            if (exp_tx.size() == 0) break;
        end
        if (n == 400) miss("tx_drain");
    endtask

    // Response format: iter, cyc_hi, cyc_lo, then U pairs of LSB-first correction bytes
    task automatic send_response();
        int n;
        logic [15:0] w;
        exp_stats.push_back({resp[0], resp[1], resp[2]});
        for (int k = 0; k < 3; k++) begin
            w = {resp[4+2*k], resp[3+2*k]};
            exp_corr.push_back(w[10:0]);
        end
        for (int i = 0; i < 9; i++) begin
            rx_data  = resp[i];
            rx_valid = 1'b1;
            for (n = 0; n < 100; n++) begin
                @(negedge clk);
                if (rx_ready) break;
            end
            if (n == 100) miss("rx_accept");
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_corr_done();
        int n;
        for (n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            if (exp_corr.size() == 0 && exp_stats.size() == 0) break;
        end
        if (n == 400) miss("corr_drain");
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, base;
        reset = 1'b0; meas_valid = 1'b0; meas_data = '0; rx_valid = 1'b0; rx_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_meas_ready", meas_ready, 0);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_corr_valid", corr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout_error, 0);
        chk("rst_counts", {iteration_count, cycle_count}, 0);
        exp_tx.push_back(START);
        reset = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            if (tx_log.size() >= 1) break;
        end
        if (n == 50) miss("start_byte");
        chk("start_literal", tx_log[0], 8'hA5);
        chk("after_start_tx_valid", tx_valid, 0);
        chk("after_start_busy", busy, 0);

        base = meas_hs;
        send_frame(8'h05, 8'h00, 8'h81);
        chk("busy_in_frame", busy, 1);
        wait_drain();
        @(posedge clk); #1;
        chk("busy_in_wait", busy, 1);
        chk("meas_handshakes", meas_hs - base, 3);
        chk("f1_hdr", tx_log[1], 8'h5A);
        chk("f1_b0", tx_log[2], 8'h05);
        chk("f1_b1", tx_log[3], 8'h00);
        chk("f1_b2", tx_log[4], 8'h81);
        resp = '{8'h02, 8'h00, 8'h1C, 8'h34, 8'h07, 8'hFF, 8'h07, 8'h00, 8'h00};
        send_response();
        wait_corr_done();
        chk("f1_busy_done", busy, 0);
        chk("f1_iter", iteration_count, 8'h02);
        chk("f1_cycle", cycle_count, 16'h001C);
        chk("f1_corr0", corr_log[0], 11'h734);
        chk("f1_corr1", corr_log[1], 11'h7FF);
        chk("f1_corr2", corr_log[2], 11'h000);
        chk("f1_stats_pulses", stats_pulses, 1);

        tog_tx = 1'b1;
        stall_corr = 1'b1;
        base = meas_hs;
        send_frame(8'hA7, 8'h3C, 8'hFF);
        wait_drain();
        @(posedge clk); #1;
        resp = '{8'h7F, 8'h12, 8'h34, 8'hB4, 8'hFA, 8'h01, 8'h00, 8'h55, 8'hAA};
        send_response();
        wait_corr_done();
        tog_tx = 1'b0;
        stall_corr = 1'b0;
        chk("f2_meas_handshakes", meas_hs - base, 3);
        chk("f2_tx_count", tx_log.size(), 9);
        chk("f2_corr0", corr_log[3], 11'h2B4);
        chk("f2_corr1", corr_log[4], 11'h001);
        chk("f2_corr2", corr_log[5], 11'h255);
        chk("f2_stats", {iteration_count, cycle_count}, 24'h7F1234);
        chk("f2_busy_done", busy, 0);
        chk("f2_no_timeout", timeout_error, 0);

        send_frame(8'h11, 8'h22, 8'h33);
        wait_drain();
        @(posedge clk);
        for (k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (timeout_error) break;
        end
        chk("timeout_latency", k, 16);
        chk("timeout_flag", timeout_error, 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_corr_valid", corr_valid, 0);

        send_frame(8'h44, 8'h55, 8'h66);
        wait_drain();
        @(posedge clk); #1;
        resp = '{8'h03, 8'hAB, 8'hCD, 8'hFF, 8'hFF, 8'h80, 8'h04, 8'h0F, 8'hF0};
        send_response();
        wait_corr_done();
        chk("f4_corr0", corr_log[6], 11'h7FF);
        chk("f4_corr1", corr_log[7], 11'h480);
        chk("f4_corr2", corr_log[8], 11'h00F);
        chk("f4_cycle", cycle_count, 16'hABCD);
        chk("f4_sticky_timeout", timeout_error, 1);
        chk("f4_busy_done", busy, 0);

        meas_data = 8'h3C;
        meas_valid = 1'b1;
        exp_tx.push_back(HDR);
        exp_tx.push_back(8'h3C);
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (meas_ready) break;
        end
        if (n == 200) miss("rst_meas_accept");
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("async_tx_valid", tx_valid, 0);
        chk("async_tx_data", tx_data, 0);
        chk("async_busy", busy, 0);
        chk("async_meas_ready", meas_ready, 0);
        chk("async_rx_ready", rx_ready, 0);
        chk("async_timeout", timeout_error, 0);
        chk("async_counts", {iteration_count, cycle_count}, 0);
        chk("async_pending_bytes", exp_tx.size(), 1);
        meas_valid = 1'b0;
        exp_tx.delete();
        repeat (2) @(posedge clk);
        #1;
        base = tx_log.size();
        exp_tx.push_back(START);
        reset = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            if (tx_log.size() > base) break;
        end
        if (n == 50) miss("restart_byte");
        chk("restart_literal", tx_log[tx_log.size()-1], 8'hA5);
        repeat (3) @(posedge clk);
        #1;
        chk("restart_busy", busy, 0);
        chk("end_tx_queue", exp_tx.size(), 0);
        chk("end_corr_queue", exp_corr.size(), 0);
        chk("end_stats_pulses", stats_pulses, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
